prog_loader: RTL and testbench

Boot-time program/data loader sitting directly upstream of the instruction and data BRAMs. It accepts a byte stream (e.g. from a UART receiver) with a valid/ready handshake and assembles little-endian 32-bit words. It drives the BRAM write ports (write address, write data, write enable) for both memories. On a run command it releases the core by deasserting the PC stall and asserting data-BRAM init-done, which hands the data-BRAM write port to the control path.

---
 rtl/prog_loader_pkg.sv | 36 +++
 rtl/prog_loader_word_assembler.sv | 38 +++
 rtl/prog_loader.sv | 147 ++++++++++++++
 tb/tb_prog_loader.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// Shared codes for the boot loader: command bytes, FSM state encoding and frame limits.
// Imported by the RTL and the testbench so both agree on every encoding.
package prog_loader_pkg;

  localparam logic [7:0] CMD_I = 8'h49;
  localparam logic [7:0] CMD_D = 8'h44;
  localparam logic [7:0] CMD_G = 8'h47;

  localparam int MAX_WORDS_DEF = 256;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CNT_LO,
    S_CNT_HI,
    S_DATA,
    S_WRITE,
    S_RUN,
    S_ERROR
  } state_t;

  typedef enum logic {
    TGT_I,
    TGT_D
  } target_t;

  // States in which a stream byte may be taken.
  function automatic logic state_ready(input state_t s);
    return (s == S_IDLE) || (s == S_CNT_LO) || (s == S_CNT_HI) || (s == S_DATA);
  endfunction

  // A frame is in flight.
  function automatic logic state_busy(input state_t s);
    return !((s == S_IDLE) || (s == S_RUN) || (s == S_ERROR));
  endfunction

endpackage

// File: rtl/prog_loader_word_assembler.sv
// Shifts stream bytes into a little-endian word; flags the byte that completes it.
// word_next presents the word including the byte being accepted this cycle.
module prog_loader_word_assembler #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  shift_en,
  input  logic [7:0]            in_dat,
  output logic [DATA_WIDTH-1:0] word_next,
  output logic                  word_last
);

  localparam int IDX_W = $clog2(DATA_WIDTH / 8);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH / 8 - 1);

  logic [DATA_WIDTH-1:0] word_q;
  logic [IDX_W-1:0]      idx_q;

  // First byte ends up in bits 7:0 after a full word of shifts.
  assign word_next = {in_dat, word_q[DATA_WIDTH-1:8]};
  assign word_last = shift_en && (idx_q == LAST_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q <= '0;
      idx_q  <= '0;
    end else if (clr) begin
      word_q <= '0;
      idx_q  <= '0;
    end else if (shift_en) begin
      word_q <= word_next;
      idx_q  <= idx_q + 1'b1;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Boot loader: parses I/D load frames from a byte stream into BRAM word writes,
// then releases the core on a run command.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WORDS  = MAX_WORDS_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            in_dat,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] i_w_addr,
  output logic [DATA_WIDTH-1:0] i_w_dat,
  output logic                  i_w_enb,
  output logic [ADDR_WIDTH-1:0] d_w_addr,
  output logic [DATA_WIDTH-1:0] d_w_dat,
  output logic                  d_w_enb,
  output logic                  pc_stall,
  output logic                  d_bram_init_done,
  output logic                  busy,
  output logic                  error
);

  localparam logic [15:0] MAX_CNT = 16'(MAX_WORDS);

  state_t                state_q, state_d;
  target_t               target_q;
  logic [7:0]            cnt_lo_q;
  logic [15:0]           remain_q;
  logic [ADDR_WIDTH-1:0] addr_q;

  logic                  accept;
  logic [15:0]           count;
  logic [DATA_WIDTH-1:0] word_next;
  logic                  word_last;
  logic                  asm_clr;

  assign accept  = in_valid && in_ready;
  assign count   = {in_dat, cnt_lo_q};
  assign asm_clr = (state_d == S_DATA) && (state_q != S_DATA);

  prog_loader_word_assembler #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_word_assembler (
    .clk       (clk),
    .rst       (rst),
    .clr       (asm_clr),
    .shift_en  (accept && (state_q == S_DATA)),
    .in_dat    (in_dat),
    .word_next (word_next),
    .word_last (word_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    // NOTE: default first so no path through the case leaves state_d unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept) begin
        if (in_dat == CMD_I || in_dat == CMD_D) state_d = S_CNT_LO;
        else if (in_dat == CMD_G)               state_d = S_RUN;
        else                                    state_d = S_ERROR;
      end
      S_CNT_LO: if (accept) state_d = S_CNT_HI;
      S_CNT_HI: if (accept) begin
        if (count == 16'd0)        state_d = S_IDLE;
        else if (count > MAX_CNT)  state_d = S_ERROR;
        else                       state_d = S_DATA;
      end
      S_DATA:  if (word_last) state_d = S_WRITE;
      S_WRITE: state_d = (remain_q == 16'd1) ? S_IDLE : S_DATA;
      S_RUN:   state_d = S_RUN;
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_ERROR;
    endcase
  end

  // Frame bookkeeping: target memory, word count and write address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      target_q <= TGT_I;
      cnt_lo_q <= '0;
      remain_q <= '0;
      addr_q   <= '0;
    end else begin
      if (state_q == S_IDLE && accept)
        target_q <= (in_dat == CMD_D) ? TGT_D : TGT_I;
      if (state_q == S_CNT_LO && accept)
        cnt_lo_q <= in_dat;
      if (state_q == S_CNT_HI && accept) begin
        remain_q <= count;
        addr_q   <= '0;
      end
      if (state_q == S_WRITE) begin
        remain_q <= remain_q - 16'd1;
        addr_q   <= addr_q + ADDR_WIDTH'(4);
      end
    end
  end

  // Registered outputs; the untargeted write port keeps its last addr/dat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready         <= 1'b0;
      i_w_addr         <= '0;
      i_w_dat          <= '0;
      i_w_enb          <= 1'b0;
      d_w_addr         <= '0;
      d_w_dat          <= '0;
      d_w_enb          <= 1'b0;
      pc_stall         <= 1'b1;
      d_bram_init_done <= 1'b0;
      busy             <= 1'b0;
      error            <= 1'b0;
    end else begin
      // NOTE: non-blocking everywhere here so each register samples pre-edge values.
      in_ready <= state_ready(state_d);
      busy     <= state_busy(state_d);
      error    <= (state_d == S_ERROR);
      i_w_enb  <= 1'b0;
      d_w_enb  <= 1'b0;
      if (word_last) begin
        if (target_q == TGT_I) begin
          i_w_enb  <= 1'b1;
          i_w_addr <= addr_q;
          i_w_dat  <= word_next;
        end else begin
          d_w_enb  <= 1'b1;
          d_w_addr <= addr_q;
          d_w_dat  <= word_next;
        end
      end
      if (state_d == S_RUN) begin
        pc_stall         <= 1'b0;
        d_bram_init_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: frame loads, run command, stalls, errors and reset.
// A negedge monitor logs every write pulse; each test compares against hand-computed words.
module tb_prog_loader;
  import prog_loader_pkg::*;

  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    in_dat;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] i_w_addr, d_w_addr;
  logic [DW-1:0] i_w_dat, d_w_dat;
  logic          i_w_enb, d_w_enb;
  logic          pc_stall, d_bram_init_done, busy, error;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] dat;
  } wr_t;

  wr_t i_q[$];
  wr_t d_q[$];
  int  errors = 0;
  int  checks = 0;

  prog_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WORDS(256)) dut (
    .clk              (clk),
    .rst              (rst),
    .in_dat           (in_dat),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .i_w_addr         (i_w_addr),
    .i_w_dat          (i_w_dat),
    .i_w_enb          (i_w_enb),
    .d_w_addr         (d_w_addr),
    .d_w_dat          (d_w_dat),
    .d_w_enb          (d_w_enb),
    .pc_stall         (pc_stall),
    .d_bram_init_done (d_bram_init_done),
    .busy             (busy),
    .error            (error)
  );

  always #5 clk = ~clk;

  // A pulse held for two cycles shows up as two entries.
  always @(negedge clk) begin
    if (!rst) begin
      if (i_w_enb) i_q.push_back({i_w_addr, i_w_dat});
      if (d_w_enb) d_q.push_back({d_w_addr, d_w_dat});
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called at a negedge; returns at the negedge after the byte was taken.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n;
    if (gaps) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 1)) @(negedge clk);
    end
    in_dat   = b;
    in_valid = 1'b1;
    n = 0;
    while (in_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      errors++; checks++;
      $display("FAIL send_byte: in_ready=%b required 1 for byte %h", in_ready, b);
    end else begin
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic send_hdr(input logic [7:0] cmd, input logic [15:0] cnt, input bit gaps);
    send_byte(cmd, gaps);
    send_byte(cnt[7:0], gaps);
    send_byte(cnt[15:8], gaps);
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gaps);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    in_dat   = 8'h00;
    rst      = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    i_q.delete();
    d_q.delete();
  endtask

  task automatic test_reset();
    in_valid = 1'b0;
    in_dat   = 8'h00;
    rst      = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({in_ready, i_w_enb, d_w_enb, pc_stall, d_bram_init_done, busy, error} !== 7'b0001000) begin
      errors++;
      $display("FAIL reset_flags: got %b required 0001000",
               {in_ready, i_w_enb, d_w_enb, pc_stall, d_bram_init_done, busy, error});
    end
    checks++;
    if ({i_w_addr, i_w_dat, d_w_addr, d_w_dat} !== '0) begin
      errors++;
      $display("FAIL reset_ports: i=%h/%h d=%h/%h required all 0", i_w_addr, i_w_dat, d_w_addr, d_w_dat);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b required 1", in_ready);
    end
  endtask

  task automatic test_load_i();
    send_hdr(CMD_I, 16'h0002, 1'b0);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL load_i_busy: got %b required 1", busy);
    end
    send_word(32'h00500013, 1'b0);
    send_word(32'h00A00293, 1'b0);
    repeat (2) @(negedge clk);
    checks++;
    if (i_q.size() != 2 || d_q.size() != 0) begin
      errors++;
      $display("FAIL load_i_count: i=%0d d=%0d required 2 and 0", i_q.size(), d_q.size());
    end else begin
      checks++;
      if (i_q[0] !== {10'h000, 32'h00500013}) begin
        errors++;
        $display("FAIL load_i_w0: got %h/%h required 000/00500013", i_q[0].addr, i_q[0].dat);
      end
      checks++;
      if (i_q[1] !== {10'h004, 32'h00A00293}) begin
        errors++;
        $display("FAIL load_i_w1: got %h/%h required 004/00a00293", i_q[1].addr, i_q[1].dat);
      end
    end
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL load_i_idle: busy=%b in_ready=%b required 0 and 1", busy, in_ready);
    end
    i_q.delete();
  endtask

  task automatic test_load_d_go();
    send_hdr(CMD_D, 16'h0001, 1'b0);
    send_word(32'h0000000A, 1'b0);
    @(negedge clk);
    checks++;
    if (d_q.size() != 1 || d_q[0] !== {10'h000, 32'h0000000A}) begin
      errors++;
      $display("FAIL load_d_w0: size=%0d entry=%h required 1 entry 000/0000000a",
               d_q.size(), (d_q.size() > 0) ? d_q[0] : '0);
    end
    checks++;
    if (i_w_addr !== 10'h004 || i_w_dat !== 32'h00A00293 || i_q.size() != 0) begin
      errors++;
      $display("FAIL load_d_i_hold: i=%h/%h pulses=%0d required 004/00a00293 and 0",
               i_w_addr, i_w_dat, i_q.size());
    end
    checks++;
    if (pc_stall !== 1'b1) begin
      errors++;
      $display("FAIL pre_go_stall: got %b required 1", pc_stall);
    end
    send_byte(CMD_G, 1'b0);
    checks++;
    if ({pc_stall, d_bram_init_done, in_ready, busy} !== 4'b0100) begin
      errors++;
      $display("FAIL go_release: stall/init/ready/busy=%b required 0100",
               {pc_stall, d_bram_init_done, in_ready, busy});
    end
    in_dat   = CMD_I;
    in_valid = 1'b1;
    repeat (6) @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (d_q.size() != 1 || i_q.size() != 0 || pc_stall !== 1'b0 || d_bram_init_done !== 1'b1) begin
      errors++;
      $display("FAIL run_terminal: d=%0d i=%0d stall=%b init=%b required 1 0 0 1",
               d_q.size(), i_q.size(), pc_stall, d_bram_init_done);
    end
  endtask

  task automatic test_random_valid();
    logic [31:0] exp_w [3];
    exp_w[0] = 32'h11223344;
    exp_w[1] = 32'hDEADBEEF;
    exp_w[2] = 32'h00000001;
    do_reset();
    send_hdr(CMD_I, 16'h0003, 1'b1);
    send_word(exp_w[0], 1'b1);
    send_byte(exp_w[1][7:0], 1'b1);
    send_byte(exp_w[1][15:8], 1'b1);
    repeat (20) @(negedge clk);
    send_byte(exp_w[1][23:16], 1'b1);
    send_byte(exp_w[1][31:24], 1'b1);
    send_word(exp_w[2], 1'b1);
    repeat (3) @(negedge clk);
    checks++;
    if (i_q.size() != 3 || d_q.size() != 0) begin
      errors++;
      $display("FAIL rand_count: i=%0d d=%0d required 3 and 0", i_q.size(), d_q.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (i_q[k] !== {AW'(4 * k), exp_w[k]}) begin
          errors++;
          $display("FAIL rand_w%0d: got %h/%h required %h/%h",
                   k, i_q[k].addr, i_q[k].dat, AW'(4 * k), exp_w[k]);
        end
      end
    end
  endtask

  task automatic test_count_bounds();
    int bad;
    do_reset();
    send_hdr(CMD_I, 16'h0000, 1'b0);
    checks++;
    if ({busy, error, in_ready} !== 3'b001 || i_q.size() != 0) begin
      errors++;
      $display("FAIL count_zero: busy/error/ready=%b pulses=%0d required 001 and 0",
               {busy, error, in_ready}, i_q.size());
    end
    send_hdr(CMD_D, 16'h0100, 1'b0);
    for (int k = 0; k < 256; k++) send_word({8'h03, 8'h02, 8'h01, 8'(k)}, 1'b0);
    repeat (2) @(negedge clk);
    bad = 0;
    if (d_q.size() != 256) bad = 1;
    else
      for (int k = 0; k < 256; k++)
        if (d_q[k] !== {AW'(4 * k), 8'h03, 8'h02, 8'h01, 8'(k)}) bad++;
    checks++;
    if (bad != 0 || i_q.size() != 0) begin
      errors++;
      $display("FAIL count_max: d=%0d bad=%0d i=%0d required 256 0 0", d_q.size(), bad, i_q.size());
    end
    checks++;
    if (d_w_addr !== 10'h3FC || error !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL count_max_last: addr=%h error=%b busy=%b required 3fc 0 0", d_w_addr, error, busy);
    end
  endtask

  task automatic test_overcount();
    do_reset();
    send_hdr(CMD_I, 16'h0101, 1'b0);
    checks++;
    if ({error, in_ready, busy, pc_stall} !== 4'b1001) begin
      errors++;
      $display("FAIL overcount: error/ready/busy/stall=%b required 1001",
               {error, in_ready, busy, pc_stall});
    end
    in_dat   = 8'h13;
    in_valid = 1'b1;
    repeat (10) @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (error !== 1'b1 || in_ready !== 1'b0 || i_q.size() != 0 || d_q.size() != 0) begin
      errors++;
      $display("FAIL overcount_sticky: error=%b ready=%b pulses=%0d/%0d required 1 0 0 0",
               error, in_ready, i_q.size(), d_q.size());
    end
  endtask

  task automatic test_bad_cmd();
    do_reset();
    send_byte(8'h55, 1'b0);
    checks++;
    if ({error, pc_stall, in_ready, d_bram_init_done} !== 4'b1100) begin
      errors++;
      $display("FAIL bad_cmd: error/stall/ready/init=%b required 1100",
               {error, pc_stall, in_ready, d_bram_init_done});
    end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    send_hdr(CMD_D, 16'h0001, 1'b0);
    send_word(32'h12345678, 1'b0);
    send_hdr(CMD_I, 16'h0001, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    checks++;
    if (d_w_dat !== 32'h12345678 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre: d_w_dat=%h busy=%b required 12345678 1", d_w_dat, busy);
    end
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({in_ready, i_w_enb, d_w_enb, pc_stall, d_bram_init_done, busy, error} !== 7'b0001000 ||
        {i_w_addr, i_w_dat, d_w_addr, d_w_dat} !== '0) begin
      errors++;
      $display("FAIL mid_async_reset: flags=%b d_w_dat=%h required 0001000 and 0",
               {in_ready, i_w_enb, d_w_enb, pc_stall, d_bram_init_done, busy, error}, d_w_dat);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    i_q.delete();
    d_q.delete();
    send_hdr(CMD_I, 16'h0001, 1'b0);
    send_word(32'hCAFEF00D, 1'b0);
    repeat (2) @(negedge clk);
    checks++;
    if (i_q.size() != 1 || i_q[0] !== {10'h000, 32'hCAFEF00D} || d_q.size() != 0) begin
      errors++;
      $display("FAIL mid_fresh: i=%0d entry=%h d=%0d required 1 entry 000/cafef00d and 0",
               i_q.size(), (i_q.size() > 0) ? i_q[0] : '0, d_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_load_i();
    test_load_d_go();
    test_random_valid();
    test_count_bounds();
    test_overcount();
    test_bad_cmd();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
